// File: rtl/pipelined_mult_acc_pkg.sv
// Shared constants for the pipelined multiplier/accumulator: latency rule and
// arithmetic mode encodings.
package pipelined_mult_acc_pkg;

  localparam int MODE_UNSIGNED       = 32'sd0;
  localparam int MODE_SIGNED         = 32'sd1;
  localparam int DEFAULT_PIPE_STAGES = 32'sd3;

  // Input register + product stages + output register.
  function automatic int calc_latency(input int pipe_stages);
    return pipe_stages + 32'sd2;
  endfunction

  localparam int DEFAULT_LATENCY = calc_latency(DEFAULT_PIPE_STAGES);

endpackage

// File: rtl/pipelined_mult_acc_pipe_delay.sv
// Width/depth parametrised shift register with clock enable, used for the
// product stages and for the valid/sideband bits that travel with them.
module pipelined_mult_acc_pipe_delay
  import pipelined_mult_acc_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain; every stage holds while CE is low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else if (CE) begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/pipelined_mult_acc.sv
// Pipelined A*B multiplier with valid-qualified datapath, clock enable,
// signed/unsigned mode and an optional wrapping accumulator with sticky overflow.
module pipelined_mult_acc
  import pipelined_mult_acc_pkg::*;
#(
  parameter int A_WIDTH     = 18,
  parameter int B_WIDTH     = 18,
  parameter int PIPE_STAGES = 3,
  parameter int SIGNED      = 0,
  parameter int ACC_WIDTH   = 48
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       IN_VALID,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  input  logic                       ACC_EN,
  input  logic                       ACC_CLR,
  output logic [A_WIDTH+B_WIDTH-1:0] MULT,
  output logic                       OUT_VALID,
  output logic [ACC_WIDTH-1:0]       ACC,
  output logic                       OVF,
  output logic                       BUSY
);

  localparam int   P_WIDTH     = A_WIDTH + B_WIDTH;
  localparam int   LATENCY     = calc_latency(PIPE_STAGES);
  localparam int   CNT_W       = $clog2(LATENCY + 1);
  localparam logic SIGNED_MODE = (SIGNED == MODE_SIGNED);

  logic [A_WIDTH-1:0]   a_r;
  logic [B_WIDTH-1:0]   b_r;
  logic                 in_valid_r;
  logic                 acc_en_r;
  logic                 acc_clr_r;
  logic [P_WIDTH-1:0]   a_ext_s;
  logic [P_WIDTH-1:0]   b_ext_s;
  (* mult_style = "pipe_lut" *)
  logic [P_WIDTH-1:0]   prod_s;
  logic [P_WIDTH-1:0]   prod_d_s;
  logic [2:0]           side_d_s;
  logic                 beat_valid_s;
  logic                 beat_en_s;
  logic                 beat_clr_s;
  logic [ACC_WIDTH-1:0] prod_ext_s;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 ovf_det_s;
  logic [CNT_W-1:0]     inflight_r;
  logic [CNT_W-1:0]     inflight_next_s;

  // Input register stage: operands and sideband captured on every enabled edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_r        <= '0;
      b_r        <= '0;
      in_valid_r <= 1'b0;
      acc_en_r   <= 1'b0;
      acc_clr_r  <= 1'b0;
    end else if (CE) begin
      a_r        <= A;
      b_r        <= B;
      in_valid_r <= IN_VALID;
      acc_en_r   <= ACC_EN;
      acc_clr_r  <= ACC_CLR;
    end
  end

  // Operand extension to product width; the low P_WIDTH bits of the product
  // of sign-extended operands equal the two's-complement product.
  always_comb begin
    a_ext_s = P_WIDTH'(a_r);
    b_ext_s = P_WIDTH'(b_r);
    for (int i = A_WIDTH; i < P_WIDTH; i++) begin
      a_ext_s[i] = SIGNED_MODE & a_r[A_WIDTH-1];
    end
    for (int i = B_WIDTH; i < P_WIDTH; i++) begin
      b_ext_s[i] = SIGNED_MODE & b_r[B_WIDTH-1];
    end
  end

  assign prod_s = a_ext_s * b_ext_s;

  pipelined_mult_acc_pipe_delay #(.WIDTH(P_WIDTH), .DEPTH(PIPE_STAGES)) u_prod_pipe (
    .CLK  (CLK),
    .RST  (RST),
    .CE   (CE),
    .din  (prod_s),
    .dout (prod_d_s)
  );

  pipelined_mult_acc_pipe_delay #(.WIDTH(3), .DEPTH(PIPE_STAGES)) u_side_pipe (
    .CLK  (CLK),
    .RST  (RST),
    .CE   (CE),
    .din  ({in_valid_r, acc_en_r, acc_clr_r}),
    .dout (side_d_s)
  );

  assign beat_valid_s = side_d_s[2];
  assign beat_en_s    = side_d_s[1];
  assign beat_clr_s   = side_d_s[0];

  // Product extended to accumulator width and the overflow detector.
  always_comb begin
    prod_ext_s = ACC_WIDTH'(prod_d_s);
    for (int i = P_WIDTH; i < ACC_WIDTH; i++) begin
      prod_ext_s[i] = SIGNED_MODE & prod_d_s[P_WIDTH-1];
    end
    sum_s = {1'b0, ACC} + {1'b0, prod_ext_s};
    if (SIGNED_MODE) begin
      ovf_det_s = (ACC[ACC_WIDTH-1] == prod_ext_s[ACC_WIDTH-1]) &&
                  (sum_s[ACC_WIDTH-1] != ACC[ACC_WIDTH-1]);
    end else begin
      ovf_det_s = sum_s[ACC_WIDTH];
    end
  end

  // Output stage: product register, valid flag, accumulator and sticky overflow.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MULT      <= '0;
      OUT_VALID <= 1'b0;
      ACC       <= '0;
      OVF       <= 1'b0;
    end else if (CE) begin
      OUT_VALID <= beat_valid_s;
      if (beat_valid_s) begin
        MULT <= prod_d_s;
        if (beat_clr_s) begin
          ACC <= prod_ext_s;
          OVF <= 1'b0;
        end else if (beat_en_s) begin
          ACC <= sum_s[ACC_WIDTH-1:0];
          OVF <= OVF | ovf_det_s;
        end
      end
    end
  end

  // Valid beats in flight: one enters with IN_VALID, one leaves as OUT_VALID shifts out.
  assign inflight_next_s = inflight_r + CNT_W'(IN_VALID) - CNT_W'(OUT_VALID);

  // Occupancy counter and registered BUSY flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      inflight_r <= '0;
      BUSY       <= 1'b0;
    end else if (CE) begin
      inflight_r <= inflight_next_s;
      BUSY       <= (inflight_next_s != '0);
    end
  end

endmodule

// File: tb/tb_pipelined_mult_acc.sv
// Scoreboard bench: an unsigned 36-bit-accumulator instance and a signed
// 48-bit-accumulator instance share one randomized stimulus stream.
module tb_pipelined_mult_acc;

  localparam int L = 5;
  localparam longint unsigned MASK36 = 64'h0000_000F_FFFF_FFFF;
  localparam longint unsigned MASK48 = 64'h0000_FFFF_FFFF_FFFF;

  typedef struct {
    int              idx;
    longint unsigned mult;
    longint unsigned acc;
    bit              ovf;
  } exp_t;

  logic        CLK, RST, CE, IN_VALID, ACC_EN, ACC_CLR;
  logic [17:0] A, B;
  logic [35:0] mult0, mult1, acc0;
  logic [47:0] acc1;
  logic        ov0, ov1, ovf0, ovf1, busy0, busy1;

  pipelined_mult_acc #(.SIGNED(0), .ACC_WIDTH(36)) u0 (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B),
    .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR), .MULT(mult0), .OUT_VALID(ov0),
    .ACC(acc0), .OVF(ovf0), .BUSY(busy0)
  );

  pipelined_mult_acc #(.SIGNED(1), .ACC_WIDTH(48)) u1 (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID), .A(A), .B(B),
    .ACC_EN(ACC_EN), .ACC_CLR(ACC_CLR), .MULT(mult1), .OUT_VALID(ov1),
    .ACC(acc1), .OVF(ovf1), .BUSY(busy1)
  );

  longint unsigned mult_v[2], acc_v[2];
  bit              ov_v[2], ovf_v[2], busy_v[2];

  always_comb begin
    mult_v[0] = 64'(mult0);  mult_v[1] = 64'(mult1);
    acc_v[0]  = 64'(acc0);   acc_v[1]  = 64'(acc1);
    ov_v[0]   = ov0;         ov_v[1]   = ov1;
    ovf_v[0]  = ovf0;        ovf_v[1]  = ovf1;
    busy_v[0] = busy0;       busy_v[1] = busy1;
  end

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int hist_q[$];
  exp_t exp_q[2][$];
  exp_t cur[2];
  longint unsigned snap_mult[2], snap_acc[2];
  bit snap_ov[2], snap_ovf[2], snap_busy[2];

  // reference model state
  longint unsigned macc0;
  bit              movf0;
  longint          macc1;
  bit              movf1;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic take_snap(input int d);
    snap_mult[d] = mult_v[d];
    snap_acc[d]  = acc_v[d];
    snap_ov[d]   = ov_v[d];
    snap_ovf[d]  = ovf_v[d];
    snap_busy[d] = busy_v[d];
  endtask

  task automatic model_reset();
    macc0 = 64'd0; movf0 = 1'b0; macc1 = 64'sd0; movf1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      exp_q[d].delete();
      cur[d] = '{idx: 0, mult: 64'd0, acc: 64'd0, ovf: 1'b0};
    end
    hist_q.delete();
  endtask

  // Expected results for one accepted valid beat, from plain integer arithmetic.
  task automatic model_push(input logic [17:0] a, input logic [17:0] b, input bit en, input bit clr);
    exp_t e;
    longint unsigned p0, s0, u;
    longint sa, sb, p1, s1;
    p0 = 64'(a) * 64'(b);
    if (clr) begin
      macc0 = p0; movf0 = 1'b0;
    end else if (en) begin
      s0 = macc0 + p0;
      if (s0 > MASK36) movf0 = 1'b1;
      macc0 = s0 & MASK36;
    end
    e = '{idx: edge_cnt + 1, mult: p0, acc: macc0, ovf: movf0};
    exp_q[0].push_back(e);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p1 = sa * sb;
    if (clr) begin
      macc1 = p1; movf1 = 1'b0;
    end else if (en) begin
      s1 = macc1 + p1;
      if (s1 > 64'sh0000_7FFF_FFFF_FFFF || s1 < -64'sh0000_8000_0000_0000) movf1 = 1'b1;
      u = longint'(s1) & MASK48;
      macc1 = u[47] ? longint'(u) - 64'sd281474976710656 : longint'(u);
    end
    e = '{idx: edge_cnt + 1, mult: longint'(p1) & MASK36, acc: longint'(macc1) & MASK48, ovf: movf1};
    exp_q[1].push_back(e);
    hist_q.push_back(edge_cnt + 1);
  endtask

  task automatic issue(input bit v, input logic [17:0] a, input logic [17:0] b, input bit en, input bit clr);
    IN_VALID = v; A = a; B = b; ACC_EN = en; ACC_CLR = clr;
    if (v && CE && !RST) model_push(a, b, en, clr);
    @(posedge CLK); #1;
  endtask

  task automatic check_dut(input int d, input bit ce_s, input bit exp_busy);
    bit   exp_ov;
    exp_t e;
    string p;
    p = $sformatf("u%0d.", d);
    if (ce_s) begin
      exp_ov = (exp_q[d].size() > 0) && (exp_q[d][0].idx + L - 1 == edge_cnt);
      chk({p, "out_valid"}, 64'(ov_v[d]), 64'(exp_ov));
      if (exp_ov) begin
        e = exp_q[d].pop_front();
        cur[d] = e;
      end
      chk({p, "mult"}, mult_v[d], cur[d].mult);
      chk({p, "acc"},  acc_v[d],  cur[d].acc);
      chk({p, "ovf"},  64'(ovf_v[d]), 64'(cur[d].ovf));
      chk({p, "busy"}, 64'(busy_v[d]), 64'(exp_busy));
    end else begin
      chk({p, "hold_mult"},  mult_v[d], snap_mult[d]);
      chk({p, "hold_acc"},   acc_v[d],  snap_acc[d]);
      chk({p, "hold_valid"}, 64'(ov_v[d]),   64'(snap_ov[d]));
      chk({p, "hold_ovf"},   64'(ovf_v[d]),  64'(snap_ovf[d]));
      chk({p, "hold_busy"},  64'(busy_v[d]), 64'(snap_busy[d]));
    end
    take_snap(d);
  endtask

  // Monitor: checks both instances 2 time units after every rising edge.
  always @(posedge CLK) begin
    bit ce_s, rst_s, exp_busy;
    ce_s  = CE;
    rst_s = RST;
    if (ce_s && !rst_s) edge_cnt++;
    #2;
    if (!rst_s) begin
      while (hist_q.size() > 0 && edge_cnt - hist_q[0] > L - 1) void'(hist_q.pop_front());
      exp_busy = (hist_q.size() > 0) && (hist_q[0] <= edge_cnt);
      for (int d = 0; d < 2; d++) check_dut(d, ce_s, exp_busy);
    end
  end

  function automatic logic [17:0] rand_op();
    logic [17:0] v;
    case ($urandom_range(0, 5))
      0:       v = 18'h3FFFF;
      1:       v = 18'h20000;
      2:       v = 18'h00000;
      default: v = 18'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    RST = 1'b1; CE = 1'b0; IN_VALID = 1'b0; A = 18'd0; B = 18'd0; ACC_EN = 1'b0; ACC_CLR = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d.reset_mult", d), mult_v[d], 64'd0);
      chk($sformatf("u%0d.reset_acc", d),  acc_v[d],  64'd0);
      chk($sformatf("u%0d.reset_flags", d), {61'd0, ov_v[d], ovf_v[d], busy_v[d]}, 64'd0);
      take_snap(d);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; CE = 1'b1;

    // single beat, then idle long enough to see OUT_VALID and BUSY drop
    issue(1'b1, 18'd3, 18'd5, 1'b0, 1'b0);
    repeat (L + 2) issue(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);

    // extremes: max operands, overflow wrap, clear, signed -2*3
    issue(1'b1, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1);
    issue(1'b1, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0);
    issue(1'b0, 18'd1, 18'd1, 1'b1, 1'b1);
    issue(1'b1, 18'd3, 18'd5, 1'b1, 1'b1);
    issue(1'b1, 18'h3FFFE, 18'd3, 1'b0, 1'b1);
    repeat (L + 1) issue(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);

    // back-to-back MAC, then the same stream with a 3-cycle stall as results emerge
    for (int rep = 0; rep < 2; rep++) begin
      issue(1'b1, 18'd1, 18'd2, 1'b0, 1'b1);
      issue(1'b1, 18'd3, 18'd4, 1'b1, 1'b0);
      issue(1'b1, 18'd5, 18'd6, 1'b1, 1'b0);
      issue(1'b1, 18'd7, 18'd8, 1'b1, 1'b0);
      issue(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);
      if (rep == 1) begin
        CE = 1'b0;
        repeat (3) issue(1'b1, 18'd9, 18'd9, 1'b1, 1'b1);
        CE = 1'b1;
      end
      repeat (L + 1) issue(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);
    end

    // asynchronous reset between edges with two beats in flight
    issue(1'b1, 18'd11, 18'd13, 1'b0, 1'b1);
    issue(1'b1, 18'd17, 18'd19, 1'b1, 1'b0);
    IN_VALID = 1'b0;
    @(negedge CLK); #1;
    RST = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d.midrst_mult", d), mult_v[d], 64'd0);
      chk($sformatf("u%0d.midrst_acc", d),  acc_v[d],  64'd0);
      chk($sformatf("u%0d.midrst_flags", d), {61'd0, ov_v[d], ovf_v[d], busy_v[d]}, 64'd0);
    end
    model_reset();
    for (int d = 0; d < 2; d++) take_snap(d);
    #1;
    RST = 1'b0;
    repeat (L + 2) issue(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);

    // randomized traffic with random stalls
    for (int i = 0; i < 400; i++) begin
      CE = ($urandom_range(0, 9) != 0);
      issue($urandom_range(0, 9) < 7, rand_op(), rand_op(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2);
    end

    CE = 1'b1;
    repeat (L + 3) issue(1'b0, 18'd0, 18'd0, 1'b0, 1'b0);
    chk("u0.drain", 64'(exp_q[0].size()), 64'd0);
    chk("u1.drain", 64'(exp_q[1].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
